// File: rtl/bcd_pkg.sv
// Shared types and constants for the two-digit BCD counter and its seven-segment decoder.
package bcd_pkg;

    typedef enum logic {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } state_t;

    localparam int BCD_W = 4;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 blank the digit.
// Only exists when BCD_COUNTER_SEVEN_SEG_EN is defined, so the default build carries no decoder.
`ifdef BCD_COUNTER_SEVEN_SEG_EN
module bcd_to_7seg
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule
`endif

// File: rtl/bcd_counter_99.sv
// Two-digit BCD up/down counter (00..MAX_VALUE) advanced by the divider's slow tick, with run/pause key.
// Define BCD_COUNTER_SEVEN_SEG_EN to add registered active-low seven-segment outputs HEX0/HEX1.
module bcd_counter_99
    import bcd_pkg::*;
#(
    parameter int MAX_VALUE     = 99,
    parameter bit START_RUNNING = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick_in,
    input  logic             run_key_n,
    input  logic             up,
    input  logic             clr,
    output logic [BCD_W-1:0] ones,
    output logic [BCD_W-1:0] tens,
    output logic             wrap,
    output logic             running
`ifdef BCD_COUNTER_SEVEN_SEG_EN
    ,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1
`endif
);

    localparam logic [BCD_W-1:0] MAX_TENS    = BCD_W'(MAX_VALUE / 10);
    localparam logic [BCD_W-1:0] MAX_ONES    = BCD_W'(MAX_VALUE % 10);
    localparam state_t           RESET_STATE = START_RUNNING ? RUN : PAUSED;

    logic       tick_meta, tick_s, tick_prev;
    logic       key_meta, key_s, key_prev;
    logic [1:0] warm_cnt;
    logic       tick_pulse, key_press, count_en;
    logic       at_max, at_zero;
    state_t     state, next_state;

    // Key idles high, so its synchronizer resets to 1 to avoid a phantom press at release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_meta <= 1'b0;
            tick_s    <= 1'b0;
            tick_prev <= 1'b0;
            key_meta  <= 1'b1;
            key_s     <= 1'b1;
            key_prev  <= 1'b1;
            warm_cnt  <= 2'd0;
        end else begin
            tick_meta <= tick_in;
            tick_s    <= tick_meta;
            tick_prev <= tick_s;
            key_meta  <= run_key_n;
            key_s     <= key_meta;
            key_prev  <= key_s;
            if (warm_cnt != 2'd3)
                warm_cnt <= warm_cnt + 2'd1;
        end
    end

    assign tick_pulse = tick_s & ~tick_prev & (warm_cnt == 2'd3);
    assign key_press  = ~key_s & key_prev;
    assign count_en   = tick_pulse & (state == RUN);
    assign at_max     = (tens == MAX_TENS) && (ones == MAX_ONES);
    assign at_zero    = (tens == 4'd0) && (ones == 4'd0);
    assign running    = (state == RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= RESET_STATE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (key_press)
            next_state = (state == RUN) ? PAUSED : RUN;
    end

    // count_en looks at the pre-toggle state, so a tick coinciding with a pause press still counts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ones <= 4'd0;
            tens <= 4'd0;
            wrap <= 1'b0;
        end else if (clr) begin
            ones <= 4'd0;
            tens <= 4'd0;
            wrap <= 1'b0;
        end else if (count_en && up) begin
            if (at_max) begin
                ones <= 4'd0;
                tens <= 4'd0;
                wrap <= 1'b1;
            end else if (ones == 4'd9) begin
                ones <= 4'd0;
                tens <= tens + 4'd1;
                wrap <= 1'b0;
            end else begin
                ones <= ones + 4'd1;
                wrap <= 1'b0;
            end
        end else if (count_en) begin
            if (at_zero) begin
                ones <= MAX_ONES;
                tens <= MAX_TENS;
                wrap <= 1'b1;
            end else if (ones == 4'd0) begin
                ones <= 4'd9;
                tens <= tens - 4'd1;
                wrap <= 1'b0;
            end else begin
                ones <= ones - 4'd1;
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

`ifdef BCD_COUNTER_SEVEN_SEG_EN
    logic [6:0] seg_ones, seg_tens;

    bcd_to_7seg u_seg_ones (.bcd(ones), .seg(seg_ones));
    bcd_to_7seg u_seg_tens (.bcd(tens), .seg(seg_tens));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            HEX0 <= SEG_0;
            HEX1 <= SEG_0;
        end else begin
            HEX0 <= seg_ones;
            HEX1 <= seg_tens;
        end
    end
`endif

endmodule

// File: doc/bcd_counter_99.md
Name: bcd_counter_99

Overview:
- Two-digit BCD up/down counter, 00..MAX_VALUE. Sits directly downstream of the clock divider.
- Consumes the divider's slow square-wave output (bit 0) as a count tick, sampled in the `clk` domain.
- A push key toggles run/pause. Digits feed the board display path.

Parameters:
- MAX_VALUE, 99, top of count range in decimal; legal 1..99. Tens/ones of MAX_VALUE are derived as constants.
- START_RUNNING, 1, state after reset: 1 = RUN, 0 = PAUSED.

Ports:
- clk  input  1  system clock (board 50 MHz)
- reset_n  input  1  asynchronous, active-low reset
- tick_in  input  1  divided clock from the clock divider (bit 0); asynchronous-looking, slow square wave
- run_key_n  input  1  run/pause push key, active-low, raw
- up  input  1  direction: 1 counts up, 0 counts down; sampled on the tick cycle
- clr  input  1  synchronous clear, active-high, clk domain
- ones  output  4  BCD ones digit
- tens  output  4  BCD tens digit
- wrap  output  1  one-cycle pulse on wrap-around
- running  output  1  1 while state is RUN

Behaviour:
- One clock (`clk`); reset is asynchronous and active-low (`reset_n`); all flops use posedge `clk` only.
- Reset values:
  - ones=0, tens=0, wrap=0.
  - State = RUN if START_RUNNING, else PAUSED; running follows the state.
  - Tick synchronizer and tick_prev = 0; key synchronizer and key_prev = 1.
  - 2-bit warm-up counter = 0.
- Tick path: 2-flop synchronizer → tick_s. tick_pulse = tick_s & ~tick_prev.
  - tick_pulse is gated off until the warm-up counter saturates at 3 (three clk cycles after reset release).
  - A tick_in already high at reset release therefore produces no count.
  - Latency: digits update on the 3rd clk edge after tick_in rises (2 sync + 1 register).
- Key path: 2-flop synchronizer → key_s. key_press = ~key_s & key_prev (falling edge). No debounce in this block.
- FSM, two states:
  - PAUSED --key_press--> RUN
  - RUN --key_press--> PAUSED
  - running = (state == RUN), registered.
- Count update, priority order per cycle:
  1. clr: ones=0, tens=0, wrap=0; FSM state unaffected.
  2. tick_pulse in RUN, up=1:
     - Value == MAX_VALUE → 00, wrap=1.
     - Else if ones==9 → ones=0, tens+1.
     - Else ones+1.
  3. tick_pulse in RUN, up=0:
     - Value == 00 → MAX_VALUE, wrap=1.
     - Else if ones==0 → ones=9, tens-1.
     - Else ones-1.
  4. Otherwise hold; wrap=0.
- wrap is high for exactly one clk cycle per wrap event.
- Simultaneous key_press and tick_pulse: the tick is evaluated against the pre-toggle state. A tick is counted if the state was RUN; the state then toggles.
- Ticks arriving while PAUSED are discarded, not queued.
- Digits never leave 0..9; the value never exceeds MAX_VALUE.
- Reset asserted mid-count returns all outputs to reset values immediately (asynchronous).

Optional Feature:
- Macro: BCD_COUNTER_SEVEN_SEG_EN.
- Defined:
  - Adds outputs HEX0[6:0] (ones) and HEX1[6:0] (tens), active-low segments {g,f,e,d,c,b,a}.
  - Registered one clk after the digit registers; reset value 7'b1000000 ("0").
- Undefined: HEX ports absent; no decoder logic.

Decomposition:
- Shared package bcd_pkg:
  - state typedef {PAUSED, RUN}.
  - BCD width constant (4).
  - Seven-segment lookup constants for 0–9, plus blank 7'b1111111 for codes 10–15.
- Sub-module bcd_to_7seg: 4-bit BCD in, 7-bit active-low segments out, combinational. Instantiated twice under the macro.

Test Plan:
- Reset with tick_in held high, START_RUNNING=1 → no count; ones=0, tens=0, running=1 after reset release.
- 12 tick_in rising edges, up=1 → tens=1, ones=2; each update lands 3 clk after its edge.
- Count up to 99, one more tick → 00 with wrap high exactly 1 cycle. Repeat with MAX_VALUE=59: 59 → 00 with wrap.
- From 00, up=0, one tick → 99 (MAX_VALUE), wrap pulse. Next tick → 98. From 10, one tick → 09.
- key press (run_key_n low 10 cycles) → running=0. 5 ticks → digits unchanged. Press again → running=1; next tick counts. Key falling edge coincident with tick in RUN → count taken, then running=0.
- clr asserted in the same cycle as tick_pulse at value 45 → 00, wrap=0, running unchanged. With BCD_COUNTER_SEVEN_SEG_EN: after clr, HEX0=HEX1=7'b1000000.
